// File: rtl/wtm_reset_sequencer.sv
// Releases NUM_STAGES reset domains in order, each after a fixed gap and gated by a per-stage ready ack.
// Optional build macro RESET_SEQ_TIMEOUT_EN forces progress after ACK_TIMEOUT cycles and flags timeout_err.
module wtm_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int GAP_CYCLES  = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [1:0]            state_dbg
);

  localparam int GH_MAX = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int CNT_MAX = (ACK_TIMEOUT > GH_MAX) ? ACK_TIMEOUT : GH_MAX;
`else
  localparam int CNT_MAX = GH_MAX;
`endif
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_GAP  = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_STAGES-1:0] rel_nxt;
  logic                  done_nxt;
  logic                  terr_nxt;
  logic                  terr_q;
  logic                  ack_seen;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= S_GAP;
      idx         <= '0;
      cnt         <= '0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      stage_rst_n <= rel_nxt;
      seq_done    <= done_nxt;
      terr_q      <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    rel_nxt   = stage_rst_n;
    done_nxt  = seq_done;
    terr_nxt  = terr_q;
    ack_seen  = 1'b0;
    case (state)
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          rel_nxt[idx] = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = S_ACK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        ack_seen = stage_ready[idx];
`ifdef RESET_SEQ_TIMEOUT_EN
        // A timed-out stage is treated exactly like an acknowledged one.
        if (!ack_seen && cnt == ACK_LAST) begin
          terr_nxt = 1'b1;
          ack_seen = 1'b1;
        end else if (!ack_seen) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
        if (ack_seen) begin
          cnt_nxt = '0;
          if (idx == IDX_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_GAP;
          end
        end
      end
      S_DONE: begin
        if (sw_rst_req) begin
          rel_nxt   = '0;
          done_nxt  = 1'b0;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_GAP;
    endcase
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif
  assign state_dbg = state;

endmodule

// File: tb/tb_wtm_reset_sequencer.sv
// Bench for wtm_reset_sequencer: per-scenario tasks checked against a release-schedule model
// computed from gap/ack/hold timing rules; honours RESET_SEQ_TIMEOUT_EN like the design.
module tb_wtm_reset_sequencer;
  localparam int NS   = 3;
  localparam int GAP  = 4;
  localparam int HOLD = 8;
  localparam int ACKT = 32;
  localparam int STUCK = 1000;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic [NS-1:0] stage_ready = '0;
  logic [NS-1:0] stage_rst_n;
  logic          seq_done;
  logic          timeout_err;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  bit terr_base = 1'b0;
  logic [NS-1:0] exp_q[$];

  always #5 clock = ~clock;

  wtm_reset_sequencer #(
    .NUM_STAGES(NS), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACKT)
  ) dut (
    .clock(clock), .rst(rst), .sw_rst_req(sw_rst_req), .stage_ready(stage_ready),
    .stage_rst_n(stage_rst_n), .seq_done(seq_done), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // Schedule model: stage k releases GAP edges after the previous ack (or after the
  // hold/reset origin), and is acked on the first edge after release that sees its ready.
  task automatic run_schedule(input int pre, input int low0, input int low1, input int low2,
                              input int sw_edge, input string name);
    int rel[NS];
    int ack[NS];
    bit tmo[NS];
    int low[NS];
    int n;
    int swe;
    bit terr_now;
    logic [NS-1:0] exp_rel;
    low = '{low0, low1, low2};
    n = 0;
    for (int k = 0; k < NS; k++) begin
      rel[k] = (k == 0) ? pre + GAP : ack[k-1] + GAP;
      tmo[k] = 1'b0;
      ack[k] = rel[k] + 1 + low[k];
`ifdef RESET_SEQ_TIMEOUT_EN
      if (low[k] >= ACKT) begin
        tmo[k] = 1'b1;
        ack[k] = rel[k] + ACKT;
      end
`endif
      if (n == 0 && ack[k] > rel[k] + 200) n = rel[k] + 60;
    end
    if (n == 0) n = ack[NS-1] + 3;
    swe = (sw_edge < 0) ? ack[0] + 1 + $urandom_range(0, GAP - 1) : sw_edge;
    exp_q.delete();
    for (int e = 1; e <= n; e++) begin
      for (int k = 0; k < NS; k++) exp_rel[k] = (e >= rel[k]);
      exp_q.push_back(exp_rel);
    end
    terr_now = terr_base;
    for (int e = 1; e <= n; e++) begin
      for (int k = 0; k < NS; k++) begin
        if (e > rel[k] && e < ack[k]) stage_ready[k] = 1'b0;
        else if (e == ack[k]) stage_ready[k] = ~tmo[k];
        else stage_ready[k] = 1'($urandom_range(0, 1));
      end
      sw_rst_req = (e == swe);
      @(posedge clock);
      #1;
      exp_rel = exp_q.pop_front();
      checks++;
      if (stage_rst_n !== exp_rel) begin
        errors++;
        $display("FAIL %s stage_rst_n edge %0d: got %b expected %b", name, e, stage_rst_n, exp_rel);
      end
      checks++;
      if (seq_done !== (e >= ack[NS-1])) begin
        errors++;
        $display("FAIL %s seq_done edge %0d: got %b expected %b", name, e, seq_done, (e >= ack[NS-1]));
      end
      for (int k = 0; k < NS; k++) if (tmo[k] && e >= ack[k]) terr_now = 1'b1;
      checks++;
      if (timeout_err !== terr_now) begin
        errors++;
        $display("FAIL %s timeout_err edge %0d: got %b expected %b", name, e, timeout_err, terr_now);
      end
    end
    sw_rst_req = 1'b0;
    terr_base = terr_now;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (stage_rst_n !== '0 || seq_done !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rst_n=%b done=%b terr=%b expected 000 0 0",
               stage_rst_n, seq_done, timeout_err);
    end
    @(negedge clock);
    rst = 1'b0;
    terr_base = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_power_up();
    run_schedule(0, 0, 0, 0, 0, "power_up");
  endtask

  task automatic test_sw_reset(input string name);
    sw_rst_req = 1'b1;
    @(posedge clock);
    #1;
    sw_rst_req = 1'b0;
    checks++;
    if (stage_rst_n !== '0 || seq_done !== 1'b0 || timeout_err !== terr_base) begin
      errors++;
      $display("FAIL %s sw_entry: got rst_n=%b done=%b terr=%b expected 000 0 %b",
               name, stage_rst_n, seq_done, timeout_err, terr_base);
    end
    run_schedule(HOLD, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, name);
  endtask

  task automatic test_slow_ack();
    apply_reset();
    run_schedule(0, 0, 20, 0, 0, "slow_ack");
  endtask

  task automatic test_sw_ignored();
    apply_reset();
    run_schedule(0, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), -1, "sw_ignored");
  endtask

  task automatic test_timeout();
    apply_reset();
    run_schedule(0, 0, STUCK, 0, 0, "timeout");
`ifdef RESET_SEQ_TIMEOUT_EN
    test_sw_reset("timeout_sw");
    apply_reset();
    run_schedule(0, 0, ACKT - 1, 0, 0, "timeout_edge");
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    stage_ready = '1;
    repeat (12) @(posedge clock);
    #1;
    checks++;
    if (stage_rst_n !== 3'b011) begin
      errors++;
      $display("FAIL async_pre: got %b expected 011", stage_rst_n);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (stage_rst_n !== '0 || seq_done !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rst_n=%b done=%b terr=%b expected 000 0 0",
               stage_rst_n, seq_done, timeout_err);
    end
    @(negedge clock);
    rst = 1'b0;
    terr_base = 1'b0;
    run_schedule(0, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 0, "async_restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      run_schedule(0, $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), 0, "rand_seq");
      test_sw_reset("rand_sw");
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_sw_reset("sw_reset");
    test_slow_ack();
    test_sw_ignored();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wtm_reset_sequencer.md
# wtm_reset_sequencer

Downstream consumer of the synchronized, delayed board reset. Releases a configurable number of reset domains one at a time: CPU bus glue, then peripherals, then the CPU. Between releases it waits a fixed gap, then waits for a per-stage ready handshake. It also re-runs the full sequence on a software reset request.

## Interface
- NUM_STAGES, 3: number of reset domains released in order, index 0 first; minimum 1.
- GAP_CYCLES, 16: clock cycles between entering a gap and releasing the next stage; minimum 1.
- HOLD_CYCLES, 64: clock cycles all stages stay asserted after a software reset request; minimum 1.
- ACK_TIMEOUT, 1024: cycles to wait for stage_ready before forcing progress; used only with timeout compiled in; minimum 1.
- clock  input  1  system clock; the only clock.
- rst  input  1  reset, asynchronous, active-high; driven by the inverted synchronized delayed reset.
- sw_rst_req  input  1  software reset request, synchronous; level sampled in DONE only.
- stage_ready  input  NUM_STAGES  per-stage "initialised" handshake; synchronous to clock, synchronized by the caller.
- stage_rst_n  output  NUM_STAGES  per-domain reset, active-low, registered.
- seq_done  output  1  high when all stages are released and acknowledged.
- timeout_err  output  1  sticky flag: a stage ack timed out.

## Operation
- States:
  - GAP: counter runs.
  - ACK: wait for stage_ready[idx].
  - DONE: sequence complete.
  - HOLD: software reset in progress.
- Reset values on rst high:
  - stage_rst_n = all 0, seq_done = 0, timeout_err = 0.
  - state = GAP, idx = 0, counter = 0.
- Counter width is $clog2 of the largest of GAP_CYCLES, HOLD_CYCLES and ACK_TIMEOUT, plus 1. It never wraps; it is cleared on every state entry.
- GAP:
  - counter increments each edge.
  - On the edge where counter == GAP_CYCLES-1: set stage_rst_n[idx] = 1, clear counter, go to ACK.
- ACK:
  - If stage_ready[idx] = 1 and idx == NUM_STAGES-1: go to DONE and set seq_done = 1 on that edge.
  - If stage_ready[idx] = 1 and idx < NUM_STAGES-1: idx++, clear counter, go to GAP.
  - Otherwise the counter increments (timeout build only).
- DONE:
  - If sw_rst_req = 1: stage_rst_n = all 0, seq_done = 0, idx = 0, counter = 0, go to HOLD.
- HOLD:
  - On the edge where counter == HOLD_CYCLES-1: clear counter, go to GAP.
- sw_rst_req is ignored outside DONE. A request during a sequence is dropped, not queued.
- stage_ready bits other than stage_ready[idx] are ignored. A stage whose ready drops after its ack does not re-enter reset.
- Released stages stay released until either a software reset from DONE or rst.
- rst mid-operation, in any state:
  - Immediately forces all outputs to their reset values.
  - The sequence restarts from stage 0 after rst deasserts.
- timeout_err is cleared only by rst; a software reset preserves it.

## Timing
- Latencies are counted in rising edges after rst deasserts, or after state entry.
- stage_rst_n[0] rises on edge GAP_CYCLES.
- ACK samples stage_ready from the first edge after release. If ready is already high, the ACK→GAP (or →DONE) transition takes exactly 1 edge.
- Stage k+1 is released GAP_CYCLES edges after the edge that accepted the ack of stage k.
- With ready always high, the last release is at NUM_STAGES·(GAP_CYCLES+1)−1. seq_done rises one edge after the last release.
- Software reset:
  - stage_rst_n falls on the edge sampling sw_rst_req in DONE.
  - stage_rst_n[0] rises HOLD_CYCLES+GAP_CYCLES edges later.
- All outputs come from flops; no combinational path from input to output.

## Configuration
- RESET_SEQ_TIMEOUT_EN defined:
  - In ACK, on the edge where counter == ACK_TIMEOUT-1 with ready still low, set timeout_err = 1.
  - Then proceed exactly as if ready had been seen, including the DONE transition.
- RESET_SEQ_TIMEOUT_EN undefined:
  - ACK waits indefinitely.
  - timeout_err is tied to 0.
  - The ACK_TIMEOUT parameter has no effect and does not affect counter width.

## Test plan
Parameters: NUM_STAGES=3, GAP_CYCLES=4, HOLD_CYCLES=8, ACK_TIMEOUT=32.
- Power-up, stage_ready=3'b111 → stage_rst_n bits rise at edges 4, 9, 14; seq_done rises at edge 15; timeout_err=0.
- stage_ready[1] held low for 20 cycles after stage 1 releases, then driven high → stage 2 releases 4 edges after ready is seen; stage_rst_n[2] stays low throughout the wait.
- Timeout build, stage_ready[1] stuck low → timeout_err=1 on the 32nd ACK edge; stage 2 releases 4 edges later; seq_done=1; no-timeout build hangs with seq_done=0.
- sw_rst_req 1-cycle pulse in DONE → stage_rst_n=3'b000 on the next edge; stage 0 re-releases 12 edges later; timeout_err value preserved.
- sw_rst_req pulsed while in GAP for stage 1 → ignored; sequence completes normally; no HOLD entered.
- rst asserted asynchronously mid-GAP for stage 2 → all outputs reset without waiting for a clock edge; full sequence restarts from stage 0 after release.
